// File: rtl/btn_arb_pkg.sv
// Shared types and the round-robin selection helper for the button event arbiter.
package btn_arb_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        OFFER = 1'b1
    } arb_state_t;

    // Upper bounds that cover every legal NUM_BTN (2..16).
    localparam int MAX_BTN  = 16;
    localparam int MAX_ID_W = 4;

    // Picks the first set bit of pending, starting just after last_grant and
    // wrapping modulo num_btn. Returns 0 when nothing is pending; callers only
    // use the result when at least one bit is set.
    function automatic logic [MAX_ID_W-1:0] next_rr(
        input logic [MAX_BTN-1:0]  pending,
        input logic [MAX_ID_W-1:0] last_grant,
        input int                  num_btn
    );
        logic                found;
        logic [MAX_ID_W-1:0] sel;
        int                  idx;
        found = 1'b0;
        sel   = '0;
        idx   = 0;
        for (int off = 1; off <= MAX_BTN; off++) begin
            if (off <= num_btn) begin
                idx = (int'(last_grant) + off) % num_btn;
                if (!found && pending[idx]) begin
                    found = 1'b1;
                    sel   = idx[MAX_ID_W-1:0];
                end else begin
                    found = found;
                end
            end else begin
                found = found;
            end
        end
        return sel;
    endfunction

endpackage

// File: rtl/btn_sync_debounce.sv
// Per-button front end: 2-flop synchronizer, rising-edge detect and a lockout
// counter. press_o pulses for one cycle on every accepted rising edge.
module btn_sync_debounce #(
    parameter int DEBOUNCE_CYCLES = 12000
) (
    input  logic clk,
    input  logic rst,
    input  logic async_i,
    output logic press_o
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

    logic             s1_q;
    logic             s2_q;
    logic             prev_q;
    logic [CNT_W-1:0] lock_cnt_q;
    logic [CNT_W-1:0] lock_cnt_d;
    logic             rise_s;

    // Edge detect and lockout next-state; edges inside the lockout are dropped.
    always_comb begin
        rise_s  = s2_q & ~prev_q;
        press_o = rise_s && (lock_cnt_q == '0);
        if (press_o) begin
            lock_cnt_d = CNT_W'(DEBOUNCE_CYCLES);
        end else if (lock_cnt_q != '0) begin
            lock_cnt_d = lock_cnt_q - CNT_W'(1);
        end else begin
            lock_cnt_d = lock_cnt_q;
        end
    end

    // Synchronizer chain, previous-level flop and lockout counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q       <= 1'b0;
            s2_q       <= 1'b0;
            prev_q     <= 1'b0;
            lock_cnt_q <= '0;
        end else begin
            s1_q       <= async_i;
            s2_q       <= s1_q;
            prev_q     <= s2_q;
            lock_cnt_q <= lock_cnt_d;
        end
    end

endmodule

// File: rtl/btn_event_arbiter.sv
// Button front-end: debounced presses are latched as pending events and
// serialized round-robin onto a single valid/ready event port.
module btn_event_arbiter
    import btn_arb_pkg::*;
#(
    parameter int NUM_BTN         = 4,
    parameter int DEBOUNCE_CYCLES = 12000
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_BTN-1:0]         async_in,
    output logic                       evt_valid,
    input  logic                       evt_ready,
    output logic [$clog2(NUM_BTN)-1:0] evt_id,
    output logic [NUM_BTN-1:0]         overflow,
    input  logic                       clr_overflow
);

    localparam int ID_W = $clog2(NUM_BTN);

    logic [NUM_BTN-1:0]  press_s;
    logic [NUM_BTN-1:0]  clr_s;
    logic [NUM_BTN-1:0]  ovf_set_s;
    logic [NUM_BTN-1:0]  pending_q;
    logic [NUM_BTN-1:0]  pending_d;
    logic [NUM_BTN-1:0]  overflow_q;
    logic [NUM_BTN-1:0]  overflow_d;
    logic                handshake_s;
    logic [MAX_ID_W-1:0] sel_full_s;
    logic [ID_W-1:0]     sel_s;

    arb_state_t          state_q;
    logic                evt_valid_q;
    logic [ID_W-1:0]     evt_id_q;
    logic [ID_W-1:0]     last_grant_q;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_BTN; gi++) begin : g_btn
            btn_sync_debounce #(
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
            ) u_sync_debounce (
                .clk    (clk),
                .rst    (rst),
                .async_i(async_in[gi]),
                .press_o(press_s[gi])
            );
        end
    endgenerate

    // Pending/overflow next-state: a press coinciding with the consuming
    // handshake of the same button re-arms pending without flagging overflow.
    always_comb begin
        handshake_s = evt_valid_q && evt_ready;
        pending_d   = pending_q;
        ovf_set_s   = '0;
        clr_s       = '0;
        for (int i = 0; i < NUM_BTN; i++) begin
            clr_s[i] = handshake_s && (evt_id_q == ID_W'(i));
            if (press_s[i]) begin
                pending_d[i] = 1'b1;
                if (pending_q[i] && !clr_s[i]) begin
                    ovf_set_s[i] = 1'b1;
                end else begin
                    ovf_set_s[i] = 1'b0;
                end
            end else if (clr_s[i]) begin
                pending_d[i] = 1'b0;
            end else begin
                pending_d[i] = pending_q[i];
            end
        end
        if (clr_overflow) begin
            overflow_d = ovf_set_s;
        end else begin
            overflow_d = overflow_q | ovf_set_s;
        end
    end

    // Round-robin candidate for the next offer.
    always_comb begin
        sel_full_s = next_rr(MAX_BTN'(pending_q), MAX_ID_W'(last_grant_q), NUM_BTN);
        sel_s      = sel_full_s[ID_W-1:0];
    end

    // Pending event latches and sticky overflow flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending_q  <= '0;
            overflow_q <= '0;
        end else begin
            pending_q  <= pending_d;
            overflow_q <= overflow_d;
        end
    end

    // Arbiter FSM with registered event outputs; IDLE is a one-cycle bubble
    // between offers so pending is always re-read after a handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            evt_valid_q  <= 1'b0;
            evt_id_q     <= '0;
            last_grant_q <= ID_W'(NUM_BTN - 1);
        end else begin
            case (state_q)
                IDLE: begin
                    if (|pending_q) begin
                        evt_id_q    <= sel_s;
                        evt_valid_q <= 1'b1;
                        state_q     <= OFFER;
                    end else begin
                        evt_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                OFFER: begin
                    if (evt_ready) begin
                        last_grant_q <= evt_id_q;
                        evt_valid_q  <= 1'b0;
                        state_q      <= IDLE;
                    end else begin
                        evt_valid_q  <= 1'b1;
                        state_q      <= OFFER;
                    end
                end
                default: begin
                    evt_valid_q <= 1'b0;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    assign evt_valid = evt_valid_q;
    assign evt_id    = evt_id_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_btn_event_arbiter.sv
// Self-checking bench for btn_event_arbiter (NUM_BTN=4, DEBOUNCE_CYCLES=8).
// Expected event ids are queued when presses are driven and popped by a
// monitor on every observed handshake.
module tb_btn_event_arbiter;

    localparam int NB = 4;
    localparam int DB = 8;

    logic          clk;
    logic          rst;
    logic [NB-1:0] async_in;
    logic          evt_valid;
    logic          evt_ready;
    logic [1:0]    evt_id;
    logic [NB-1:0] overflow;
    logic          clr_overflow;

    int checks;
    int errors;
    int hs_count;
    logic [1:0] exp_q[$];

    btn_event_arbiter #(
        .NUM_BTN        (NB),
        .DEBOUNCE_CYCLES(DB)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .async_in    (async_in),
        .evt_valid   (evt_valid),
        .evt_ready   (evt_ready),
        .evt_id      (evt_id),
        .overflow    (overflow),
        .clr_overflow(clr_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard monitor: every handshake must match the oldest expected id.
    always @(negedge clk) begin
        if (!rst && evt_valid && evt_ready) begin
            hs_count++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected: got event id %0d, expected no event", evt_id);
            end else begin
                logic [1:0] e;
                e = exp_q.pop_front();
                if (evt_id !== e) begin
                    errors++;
                    $display("FAIL sb_id: got %0d expected %0d", evt_id, e);
                end
            end
        end
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic check_drained(input string name);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s: %0d expected events never reported, expected 0", name, exp_q.size());
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; async_in = 4'b0000; evt_ready = 1'b0; clr_overflow = 1'b0;
        wait_cycles(2);
        rst = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            checks++;
            if (evt_valid !== 1'b0 || evt_id !== 2'd0 || overflow !== 4'b0000) begin
                errors++;
                $display("FAIL reset_idle: valid=%b id=%0d ovf=%b expected 0/0/0000", evt_valid, evt_id, overflow);
            end
        end
    endtask

    task automatic test_single_press;
        int h0;
        evt_ready = 1'b1;
        wait_cycles(1);
        h0 = hs_count;
        async_in[2] = 1'b1;
        exp_q.push_back(2'd2);
        for (int c = 0; c <= 4; c++) begin
            @(posedge clk);
            @(negedge clk);
            checks++;
            if (evt_valid !== (c == 3)) begin
                errors++;
                $display("FAIL latency_valid: cycle k+%0d valid=%b expected %b", c, evt_valid, (c == 3));
            end
            if (c == 3) begin
                checks++;
                if (evt_id !== 2'd2) begin
                    errors++;
                    $display("FAIL latency_id: got %0d expected 2", evt_id);
                end
            end
        end
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            checks++;
            if (evt_valid !== 1'b0) begin
                errors++;
                $display("FAIL single_no_repeat: valid=%b expected 0", evt_valid);
            end
        end
        checks++;
        if (hs_count - h0 !== 1) begin
            errors++;
            $display("FAIL single_count: %0d handshakes expected 1", hs_count - h0);
        end
        check_drained("single_drain");
        #1;
        async_in[2] = 1'b0;
        wait_cycles(12);
    endtask

    task automatic test_lockout;
        int h0;
        evt_ready = 1'b1;
        h0 = hs_count;
        async_in[1] = 1'b1;
        exp_q.push_back(2'd1);
        for (int c = 0; c < 6; c++) begin
            wait_cycles(1);
            async_in[1] = ~async_in[1];
        end
        wait_cycles(20);
        @(negedge clk);
        checks++;
        if (hs_count - h0 !== 1) begin
            errors++;
            $display("FAIL lockout_count: %0d events expected 1", hs_count - h0);
        end
        checks++;
        if (overflow !== 4'b0000) begin
            errors++;
            $display("FAIL lockout_ovf: got %b expected 0000", overflow);
        end
        check_drained("lockout_drain");
        #1;
        async_in[1] = 1'b0;
        wait_cycles(12);
    endtask

    task automatic test_overflow;
        int h0;
        evt_ready = 1'b0;
        async_in[0] = 1'b1;
        exp_q.push_back(2'd0);
        for (int c = 0; c <= 16; c++) begin
            @(posedge clk);
            #2;
            if (c == 4)  async_in[0] = 1'b0;
            if (c == 12) async_in[0] = 1'b1;
            @(negedge clk);
            if (c >= 3) begin
                checks++;
                if (evt_valid !== 1'b1 || evt_id !== 2'd0) begin
                    errors++;
                    $display("FAIL hold_stable: cycle %0d valid=%b id=%0d expected 1/0", c, evt_valid, evt_id);
                end
            end
            if (c == 10) begin
                checks++;
                if (overflow !== 4'b0000) begin
                    errors++;
                    $display("FAIL ovf_early: got %b expected 0000", overflow);
                end
            end
        end
        checks++;
        if (overflow !== 4'b0001) begin
            errors++;
            $display("FAIL ovf_set: got %b expected 0001", overflow);
        end
        h0 = hs_count;
        wait_cycles(1);
        evt_ready = 1'b1;
        wait_cycles(6);
        @(negedge clk);
        checks++;
        if (hs_count - h0 !== 1 || evt_valid !== 1'b0) begin
            errors++;
            $display("FAIL ovf_handshake: %0d events valid=%b expected 1 event valid=0", hs_count - h0, evt_valid);
        end
        checks++;
        if (overflow !== 4'b0001) begin
            errors++;
            $display("FAIL ovf_sticky: got %b expected 0001", overflow);
        end
        wait_cycles(1);
        clr_overflow = 1'b1;
        wait_cycles(1);
        clr_overflow = 1'b0;
        @(negedge clk);
        checks++;
        if (overflow !== 4'b0000) begin
            errors++;
            $display("FAIL ovf_clear: got %b expected 0000", overflow);
        end
        check_drained("ovf_drain");
        #1;
        async_in[0] = 1'b0;
        wait_cycles(12);
    endtask

    task automatic test_round_robin;
        evt_ready = 1'b1;
        async_in[1] = 1'b1;
        exp_q.push_back(2'd1);
        wait_cycles(8);
        async_in[1] = 1'b0;
        wait_cycles(12);
        check_drained("rr_first_drain");
        async_in[0] = 1'b1;
        async_in[2] = 1'b1;
        exp_q.push_back(2'd2);
        exp_q.push_back(2'd0);
        for (int c = 0; c <= 6; c++) begin
            @(posedge clk);
            @(negedge clk);
            checks++;
            if (evt_valid !== (c == 3 || c == 5)) begin
                errors++;
                $display("FAIL rr_valid: cycle k+%0d valid=%b expected %b", c, evt_valid, (c == 3 || c == 5));
            end
            if (c == 3 || c == 5) begin
                checks++;
                if (evt_id !== ((c == 3) ? 2'd2 : 2'd0)) begin
                    errors++;
                    $display("FAIL rr_order: cycle k+%0d id=%0d expected %0d", c, evt_id, (c == 3) ? 2 : 0);
                end
            end
        end
        check_drained("rr_drain");
        #1;
        async_in = 4'b0000;
        wait_cycles(12);
    endtask

    task automatic test_reset_mid;
        int h0;
        evt_ready = 1'b0;
        async_in[3] = 1'b1;
        async_in[0] = 1'b1;
        wait_cycles(6);
        @(negedge clk);
        checks++;
        if (evt_valid !== 1'b1 || evt_id !== 2'd3) begin
            errors++;
            $display("FAIL mid_pre: valid=%b id=%0d expected 1/3", evt_valid, evt_id);
        end
        @(posedge clk);
        #2;
        rst = 1'b1;
        async_in = 4'b0000;
        #1;
        checks++;
        if (evt_valid !== 1'b0 || evt_id !== 2'd0) begin
            errors++;
            $display("FAIL mid_async_drop: valid=%b id=%0d expected 0/0", evt_valid, evt_id);
        end
        wait_cycles(2);
        rst = 1'b0;
        evt_ready = 1'b1;
        h0 = hs_count;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            checks++;
            if (evt_valid !== 1'b0 || overflow !== 4'b0000) begin
                errors++;
                $display("FAIL mid_after: valid=%b ovf=%b expected 0/0000", evt_valid, overflow);
            end
        end
        checks++;
        if (hs_count != h0) begin
            errors++;
            $display("FAIL mid_no_event: %0d events expected 0", hs_count - h0);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        hs_count = 0;
        rst = 1'b1;
        async_in = 4'b0000;
        evt_ready = 1'b0;
        clr_overflow = 1'b0;
        test_reset();
        test_single_press();
        test_lockout();
        test_overflow();
        test_round_robin();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
